reg_file_walker: RTL and testbench

Bulk access sequencer for the 32 x 32-bit register file: it drives the register file's read and write ports. On a command it either dumps a contiguous run of registers onto a valid/ready output stream, or loads a run of registers from a valid/ready input stream. It sits between the debug/test-load path and the register file, and is used while the CPU is halted. It is the initiator side of the register file's port protocol: raddr → combinational rdata, and waddr/wen/wdata committed on the clk edge.

---
 rtl/reg_file_walker.sv | 154 +++++++++++++++
 tb/tb_reg_file_walker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_walker.sv
// Bulk dump/load sequencer driving the 32 x 32-bit register file ports.
// Latency: first dump beat valid one cycle after DUMP entry; load writes commit on the accepting edge.
// Backpressure: dump beats stall (held stable) on out_ready low; load accepts one beat per cycle while beats remain.
module reg_file_walker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_wen,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} state_t;

  // A zero count means the whole register file.
  localparam logic [ADDR_WIDTH:0]   REM_ALL  = (ADDR_WIDTH+1)'(NUM);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;

  logic issue;
  logic out_fire;
  logic load_fire;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

  // Next-state, beat issue/accept and register-file port drive for each state.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    issue       = 1'b0;
    load_fire   = 1'b0;
    out_fire    = out_valid_q && out_ready;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    rf_raddr    = '0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    rf_wen      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = (cmd_count == '0) ? REM_ALL : cmd_count;
          state_d     = cmd_op ? LOAD : DUMP;
        end
      end

      DUMP: begin
        rf_raddr = cur_addr_q;
        // A new beat may replace the current one in the same cycle it is taken.
        issue = (remaining_q != '0) && (!out_valid_q || out_ready);
        if (issue) begin
          out_data_d  = rf_rdata;
          out_addr_d  = cur_addr_q;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == REM_ONE);
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end
        if (out_fire && out_last_q) begin
          state_d = DONE;
        end
      end

      LOAD: begin
        in_ready  = (remaining_q != '0);
        load_fire = in_valid && in_ready;
        if (load_fire) begin
          rf_waddr    = cur_addr_q;
          rf_wdata    = in_data;
          // Register 0 is hardwired; its beat is consumed but never written.
          rf_wen      = (cur_addr_q != '0);
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output-beat registers; reset aborts any command and drops a pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_reg_file_walker.sv
// Randomized scoreboard bench for reg_file_walker with a behavioural register-file model.
// Latency: checks dump/done timing against command acceptance.
// Backpressure: out_ready driven always-high, 1-0-0 pattern, or random.
module tb_reg_file_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [4:0]  cmd_addr;
  logic [5:0]  cmd_count;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [4:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_wen, busy, done;

  always #5 clk = ~clk;

  reg_file_walker #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .busy(busy), .done(done)
  );

  // Register file seen by the DUT, plus a bench-side preload port.
  logic [31:0] rf_mem [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
    if (pl_en)  rf_mem[pl_addr]  <= pl_data;
  end
  assign rf_rdata = rf_mem[rf_raddr];

  // Reference contents: what each register should hold.
  logic [31:0] ref_rf [32];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t sb[$];
  beat_t mon_exp;
  beat_t held;
  logic  stall_q = 1'b0;

  // Monitor: compares every accepted dump beat against the scoreboard, checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data",  out_data,        held.d);
        chk("stall_addr",  32'(out_addr),   32'(held.a));
        chk("stall_last",  32'(out_last),   32'(held.l));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got addr %0d data 0x%0h, expected no beat", out_addr, out_data);
        end else begin
          mon_exp = sb.pop_front();
          chk("beat_addr", 32'(out_addr), 32'(mon_exp.a));
          chk("beat_data", out_data,      mon_exp.d);
          chk("beat_last", 32'(out_last), 32'(mon_exp.l));
        end
      end
      if (rf_wen) chk("wen_at_r0", 32'(rf_waddr == 5'd0), 32'd0);
      stall_q <= out_valid && !out_ready;
      held    <= {out_addr, out_data, out_last};
    end
  end

  // Sink backpressure generator.
  int ready_mode = 0;
  int ph = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = (ph % 3 == 0); ph++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic preload(input logic [4:0] r, input logic [31:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = r; pl_data = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_rf[r] = v;
  endtask

  task automatic send_cmd(input logic op, input logic [4:0] a, input logic [5:0] c);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_count = c;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    chk(name, 32'({cmd_ready, busy, done, in_ready, out_valid, rf_wen}), 32'b100000);
  endtask

  task automatic do_dump(input logic [4:0] a, input logic [5:0] c, input int mode, input bit noise);
    int    n;
    int    cyc;
    bit    got;
    beat_t b;
    n = (c == 0) ? 32 : int'(c);
    for (int i = 0; i < n; i++) begin
      b.a = 5'((int'(a) + i) % 32);
      b.d = ref_rf[b.a];
      b.l = (i == n - 1);
      sb.push_back(b);
    end
    ready_mode = mode;
    send_cmd(1'b0, a, c);
    cyc = 0;
    got = 0;
    while (cyc < 8 * n + 40) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
      cyc++;
      if (noise) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 1'b1;
        cmd_addr  = 5'($urandom);
        cmd_count = 6'($urandom);
      end
    end
    cmd_valid = 1'b0;
    chk("dump_done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("dump_busy_in_done", 32'(busy), 32'd1);
      if (mode == 0) chk("dump_latency", 32'(cyc), 32'(n + 1));
      @(negedge clk);
      check_idle("dump_idle_after_done");
    end
    chk("dump_sb_empty", 32'(sb.size()), 32'd0);
    ready_mode = 0;
  endtask

  task automatic do_load(input logic [4:0] a, input logic [5:0] c, input logic [31:0] base,
                         input bit gaps, input int abort_n);
    int         n;
    int         i;
    int         cyc;
    logic [4:0] addr;
    n = (c == 0) ? 32 : int'(c);
    i = 0;
    cyc = 0;
    addr = a;
    send_cmd(1'b1, a, c);
    while (i < n && cyc < 8 * n + 40) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = base + 32'(i);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (addr != 5'd0) ref_rf[addr] = in_data;
        addr++;
        i++;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_n != 0 && i == abort_n) break;
    end
    in_valid = 1'b0;
    if (abort_n != 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle("rst_idle_ctrl");
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_addr", 32'(out_addr), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
    end else begin
      chk("load_beats", 32'(i), 32'(n));
      @(negedge clk);
      chk("load_done_pulse", 32'({done, busy}), 32'b11);
      @(negedge clk);
      check_idle("load_idle_after_done");
    end
  endtask

  task automatic check_rf();
    for (int r = 0; r < 32; r++) chk($sformatf("rf_r%0d", r), rf_mem[r], ref_rf[r]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_count = '0;
    in_valid = 1'b0; in_data = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_ctrl");
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_addr", 32'(out_addr), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    preload(5'd0, 32'd0);
    for (int r = 1; r < 32; r++) preload(5'(r), $urandom);
    preload(5'd2, 32'h11);
    preload(5'd3, 32'h22);
    preload(5'd4, 32'h33);
    preload(5'd5, 32'h44);

    // Back-to-back dump, then the same dump under 1-0-0 backpressure.
    do_dump(5'd2, 6'd4, 0, 1'b0);
    do_dump(5'd2, 6'd4, 1, 1'b0);

    // Wrapping load with input gaps; r0 must stay zero.
    do_load(5'd30, 6'd4, 32'hA0, 1'b1, 0);
    check_rf();

    // Full-file load then full-file dump from a non-zero start.
    do_load(5'd0, 6'd0, 32'h100, 1'b0, 0);
    do_dump(5'd7, 6'd0, 0, 1'b0);
    do_dump(5'd7, 6'd0, 2, 1'b0);

    // Reset after the second beat of an eight-beat load.
    do_load(5'd9, 6'd8, 32'hC0, 1'b0, 2);
    check_rf();

    // Stray commands during a dump must be ignored.
    do_dump(5'd20, 6'd6, 2, 1'b1);

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_load(5'($urandom), 6'($urandom_range(0, 32)), $urandom, 1'b1, 0);
      else
        do_dump(5'($urandom), 6'($urandom_range(0, 32)), 2, 1'b1);
    end
    check_rf();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
